// File: rtl/pipelined_prefix_adder.sv
// rtl/pipelined_prefix_adder.sv - pipelined Kogge-Stone adder/subtractor with valid/ready handshake and sideband tag
//
// Purpose:
//   Kogge-Stone parallel-prefix add/subtract over a WIDTH+1 bit carry vector
//   (bit 0 is the effective carry-in). A pipeline rank is placed after every
//   REG_EVERY prefix layers. The last rank also forms sum/c_out/ovf and drives
//   the outputs straight from its registers.
//
// Optional feature:
//   PIPELINED_PREFIX_ADDER_SAT_EN - when defined, the last rank saturates sum
//   on signed overflow. ovf and c_out are reported unchanged.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operation offered
//   in_ready   operation accepted this cycle when in_valid is also high
//   a, b       operands (WIDTH bits)
//   c_in       carry-in (add) / borrow-in (sub)
//   sub        0: a+b+c_in, 1: a-b-c_in
//   in_tag     sideband tag, returned with the result
//   out_valid  result available
//   out_ready  consumer accepts the result
//   sum        result (WIDTH bits)
//   c_out      raw carry out of the MSB (sub: 1 = no borrow)
//   ovf        two's-complement signed overflow
//   out_tag    tag of this result
module pipelined_prefix_adder #(
  parameter int WIDTH     = 8,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int L  = $clog2(WIDTH + 1);
  localparam int R  = (L + REG_EVERY - 1) / REG_EVERY;
  localparam int RM = (R > 1) ? R - 1 : 1;

  // Applies prefix layers lo..hi to (G, A). Descending index order lets each
  // bit read its lower neighbour's value from the previous layer in place.
  function automatic logic [WIDTH:0] prefix_g(input logic [WIDTH:0] g_in,
                                              input logic [WIDTH:0] a_in,
                                              input int lo, input int hi);
    logic [WIDTH:0] g;
    logic [WIDTH:0] pa;
    g  = g_in;
    pa = a_in;
    for (int l = lo; l <= hi; l++) begin
      for (int i = WIDTH; i >= (1 << l); i--) begin
        g[i]  = g[i] | (pa[i] & g[i - (1 << l)]);
        pa[i] = pa[i] & pa[i - (1 << l)];
      end
    end
    return g;
  endfunction

  function automatic logic [WIDTH:0] prefix_a(input logic [WIDTH:0] a_in,
                                              input int lo, input int hi);
    logic [WIDTH:0] pa;
    pa = a_in;
    for (int l = lo; l <= hi; l++) begin
      for (int i = WIDTH; i >= (1 << l); i--) begin
        pa[i] = pa[i] & pa[i - (1 << l)];
      end
    end
    return pa;
  endfunction

  logic [WIDTH-1:0] beff;
  assign beff = sub ? ~b : b;

  // Intermediate rank storage (ranks 1..R-1); the last rank stores the result.
  logic [WIDTH:0]   g_q     [1:RM];
  logic [WIDTH:0]   a_q     [1:RM];
  logic [WIDTH-1:0] p_q     [1:RM];
  logic             amsb_q  [1:RM];
  logic             vld_q   [1:R];
  logic [TAG_W-1:0] tag_q   [1:R];
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // adv[k]: rank k loads this cycle. Combinational chain from out_ready so
  // a bubble anywhere in the pipe is filled immediately.
  logic [R+1:1] adv;
  assign adv[R+1]  = out_ready;
  assign in_ready  = rst_n & adv[1];

  for (genvar k = 1; k <= R; k++) begin : g_rank
    localparam int LO = (k - 1) * REG_EVERY;
    localparam int HI = ((k * REG_EVERY < L) ? k * REG_EVERY : L) - 1;

    logic [WIDTH:0]   g_src;
    logic [WIDTH:0]   a_src;
    logic [WIDTH-1:0] p_src;
    logic             amsb_src;
    logic             vld_src;
    logic [TAG_W-1:0] tag_src;
    logic [WIDTH:0]   g_d;

    if (k == 1) begin : g_src_in
      // Position 0 is the carry-in: generates cin_eff, never propagates.
      assign g_src    = {a & beff, sub ^ c_in};
      assign a_src    = {a | beff, 1'b0};
      assign p_src    = a ^ beff;
      assign amsb_src = a[WIDTH-1];
      assign vld_src  = in_valid & in_ready;
      assign tag_src  = in_tag;
    end else begin : g_src_rank
      assign g_src    = g_q[k-1];
      assign a_src    = a_q[k-1];
      assign p_src    = p_q[k-1];
      assign amsb_src = amsb_q[k-1];
      assign vld_src  = vld_q[k-1];
      assign tag_src  = tag_q[k-1];
    end

    assign g_d    = prefix_g(g_src, a_src, LO, HI);
    assign adv[k] = ~vld_q[k] | adv[k+1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end else if (adv[k]) begin
        vld_q[k] <= vld_src;
        tag_q[k] <= tag_src;
      end
    end

    if (k < R) begin : g_mid
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          g_q[k]    <= '0;
          a_q[k]    <= '0;
          p_q[k]    <= '0;
          amsb_q[k] <= 1'b0;
        end else if (adv[k]) begin
          g_q[k]    <= g_d;
          a_q[k]    <= prefix_a(a_src, LO, HI);
          p_q[k]    <= p_src;
          amsb_q[k] <= amsb_src;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] sum_raw;
      logic [WIDTH-1:0] sum_d;
      logic             ovf_d;
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
      logic [WIDTH-1:0] sat_min;
`endif

      always_comb begin
        sum_raw = p_src ^ g_d[WIDTH-1:0];
        // Operand MSBs equal exactly when p[MSB] is 0.
        ovf_d   = ~p_src[WIDTH-1] & (sum_raw[WIDTH-1] ^ amsb_src);
        sum_d   = sum_raw;
`ifdef PIPELINED_PREFIX_ADDER_SAT_EN
        sat_min            = '0;
        sat_min[WIDTH-1]   = 1'b1;
        if (ovf_d) begin
          sum_d = amsb_src ? sat_min : ~sat_min;
        end
`endif
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv[k]) begin
          sum_q  <= sum_d;
          cout_q <= g_d[WIDTH];
          ovf_q  <= ovf_d;
        end
      end
    end
  end

  assign out_valid = vld_q[R];
  assign out_tag   = tag_q[R];
  assign sum       = sum_q;
  assign c_out     = cout_q;
  assign ovf       = ovf_q;

endmodule
